blink_rate_ctrl: RTL

BLINK_RATE_CTRL -- requirements
Module: blink_rate_ctrl

---
 rtl/blink_rate_pkg.sv | 19 +
 rtl/blink_rate_ctrl_if.sv | 21 ++
 rtl/key_debounce.sv | 49 ++++
 rtl/blink_rate_ctrl.sv | 85 ++++++++
 4 files changed

// File: rtl/blink_rate_pkg.sv
// rtl/blink_rate_pkg.sv - shared widths, default limits and FSM states for the blink rate controller
package blink_rate_pkg;

  localparam int DW = 28;

  localparam logic [DW-1:0] DEFAULT_D_DEF    = 28'd25000000;
  localparam logic [DW-1:0] STEP_D_DEF       = 28'd5000000;
  localparam logic [DW-1:0] MIN_D_DEF        = 28'd5000000;
  localparam logic [DW-1:0] MAX_D_DEF        = 28'd50000000;
  localparam logic [19:0]   DEBOUNCE_CYC_DEF = 20'd500000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP_UP = 2'd1,
    STEP_DN = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/blink_rate_ctrl_if.sv
// rtl/blink_rate_ctrl_if.sv - push-button inputs and divisor outputs of the blink rate controller
interface blink_rate_ctrl_if import blink_rate_pkg::*; ();

  logic          key_up_n;
  logic          key_dn_n;
  logic [DW-1:0] dnew;
  logic          dnew_upd;
  logic          at_min;
  logic          at_max;

  modport master (
    output key_up_n, key_dn_n,
    input  dnew, dnew_upd, at_min, at_max
  );

  modport slave (
    input  key_up_n, key_dn_n,
    output dnew, dnew_upd, at_min, at_max
  );

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer, debounce counter and press (falling edge) detector for one key
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic        sync1;
  logic        sync2;
  logic        armed;
  logic [19:0] cnt;
  logic        pend;
  logic        hit;

  // Until a released level has been seen after reset, only a stable high can be accepted,
  // so a key held through reset never fires.
  assign pend = armed ? (sync2 != level) : sync2;
  assign hit  = pend && (cnt == DEBOUNCE_CYC - 20'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (!pend) begin
        cnt <= '0;
      end else if (hit) begin
        cnt   <= '0;
        level <= sync2;
        armed <= 1'b1;
        press <= armed && !sync2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// rtl/blink_rate_ctrl.sv - key-driven blink divisor: debounced up/down presses step a saturating divisor
module blink_rate_ctrl import blink_rate_pkg::*; #(
  parameter logic [DW-1:0] DEFAULT_D    = DEFAULT_D_DEF,
  parameter logic [DW-1:0] STEP_D       = STEP_D_DEF,
  parameter logic [DW-1:0] MIN_D        = MIN_D_DEF,
  parameter logic [DW-1:0] MAX_D        = MAX_D_DEF,
  parameter logic [19:0]   DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  blink_rate_ctrl_if.slave bus
);

  logic          up_lvl, up_ev;
  logic          dn_lvl, dn_ev;
  state_t        state, state_nxt;
  logic          load;
  logic [DW-1:0] d_nxt;
  logic [DW-1:0] dnew_q;
  logic          upd_q, at_min_q, at_max_q;
  logic [DW:0]   sum, diff;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_up (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_up_n), .level(up_lvl), .press(up_ev)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_dn (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_dn_n), .level(dn_lvl), .press(dn_ev)
  );

  // One extra bit keeps the borrow/carry visible to the saturation compare.
  assign sum  = {1'b0, dnew_q} + {1'b0, STEP_D};
  assign diff = {1'b0, dnew_q} - {1'b0, STEP_D};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    d_nxt     = dnew_q;
    case (state)
      IDLE: begin
        if (up_ev && dn_ev)  state_nxt = HOLD;
        else if (up_ev)      state_nxt = STEP_UP;
        else if (dn_ev)      state_nxt = STEP_DN;
      end
      STEP_UP: begin
        load      = 1'b1;
        d_nxt     = (diff[DW] || (diff < {1'b0, MIN_D})) ? MIN_D : diff[DW-1:0];
        state_nxt = HOLD;
      end
      STEP_DN: begin
        load      = 1'b1;
        d_nxt     = (sum > {1'b0, MAX_D}) ? MAX_D : sum[DW-1:0];
        state_nxt = HOLD;
      end
      HOLD: begin
        if (up_lvl && dn_lvl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dnew_q   <= DEFAULT_D;
      upd_q    <= 1'b0;
      at_min_q <= (DEFAULT_D == MIN_D);
      at_max_q <= (DEFAULT_D == MAX_D);
    end else begin
      state <= state_nxt;
      upd_q <= load && (d_nxt != dnew_q);
      if (load) begin
        dnew_q   <= d_nxt;
        at_min_q <= (d_nxt == MIN_D);
        at_max_q <= (d_nxt == MAX_D);
      end
    end
  end

  assign bus.dnew     = dnew_q;
  assign bus.dnew_upd = upd_q;
  assign bus.at_min   = at_min_q;
  assign bus.at_max   = at_max_q;

endmodule
